// File: rtl/sum_para_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sum_para_pkg
// Description : Shared types for the sum_para loadable counter (FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package sum_para_pkg;

    // Counter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sum_para.sv
`default_nettype none
// ============================================================================
// Module      : sum_para
// Description : N-bit start/stop counter with terminal-count pulse, one-shot
//               or wrapping mode, and a synchronous parallel-load override.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_para
    import sum_para_pkg::*;
#(
    parameter int N = 4
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         en,
    input  logic         wrap,
    input  logic [N-1:0] limit,
    input  logic         we,
    input  logic [N-1:0] wq,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         busy,
    output logic         done
);

    localparam logic [N-1:0] c_zero = '0;
    localparam logic [N-1:0] c_one  = {{(N-1){1'b0}}, 1'b1};

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_q;
    logic [N-1:0]   w_q_nxt;
    logic           r_tc;
    logic           w_tc_nxt;
    logic           r_busy;
    logic           r_done;

    // Next state / next count / terminal pulse. The load strobe is applied
    // last so it overrides any count update but never alters the transition.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_tc_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                // stop outranks start even when already idle
                if (start && !stop) begin
                    w_state_nxt = COUNT;
                    w_q_nxt     = c_zero;
                end
            end
            COUNT: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (start) begin
                    // restart from zero without a terminal pulse
                    w_q_nxt = c_zero;
                end else if (en) begin
                    if (r_q == limit) begin
                        w_tc_nxt = 1'b1;
                        if (wrap) begin
                            w_q_nxt = c_zero;
                        end else begin
                            w_state_nxt = DONE;
                        end
                    end else begin
                        // natural modulo 2^N rollover handles q > limit after a load
                        w_q_nxt = r_q + c_one;
                    end
                end
            end
            DONE: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (start) begin
                    w_state_nxt = COUNT;
                    w_q_nxt     = c_zero;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (we) begin
            w_q_nxt  = wq;
            w_tc_nxt = 1'b0;
        end
    end

    // State, count, pulse and status flags all registered together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_q     <= c_zero;
            r_tc    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_tc    <= w_tc_nxt;
            r_busy  <= (w_state_nxt == COUNT);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    assign q    = r_q;
    assign tc   = r_tc;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sum_para.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_para
// Description : Self-checking bench for sum_para: directed vector table,
//               hand-written corner sequences, width sweep and randomized
//               traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_para;

    logic       clk = 1'b0;
    logic       reset, start, stop, en, wrap, we;
    logic [3:0] limit, wq, q;
    logic       tc, busy, done;

    // width sweep instances (N=2 and N=6), one-shot to all-ones
    logic       s_start;
    logic [1:0] q2;
    logic [5:0] q6;
    logic       tc2, busy2, done2, tc6, busy6, done6;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       start, stop, en, wrap;
        logic [3:0] limit;
        logic       we;
        logic [3:0] wq;
        logic [3:0] eq;
        logic       etc, ebusy, edone;
    } vec_t;

    vec_t vecs[25];

    always #5 clk = ~clk;

    sum_para #(.N(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en),
        .wrap(wrap), .limit(limit), .we(we), .wq(wq),
        .q(q), .tc(tc), .busy(busy), .done(done)
    );

    sum_para #(.N(2)) dut2 (
        .clk(clk), .reset(reset), .start(s_start), .stop(1'b0), .en(1'b1),
        .wrap(1'b0), .limit(2'b11), .we(1'b0), .wq(2'b00),
        .q(q2), .tc(tc2), .busy(busy2), .done(done2)
    );

    sum_para #(.N(6)) dut6 (
        .clk(clk), .reset(reset), .start(s_start), .stop(1'b0), .en(1'b1),
        .wrap(1'b0), .limit(6'h3f), .we(1'b0), .wq(6'h00),
        .q(q6), .tc(tc6), .busy(busy6), .done(done6)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk4(input string nm, input logic [3:0] eq, input logic etc,
                        input logic ebusy, input logic edone);
        chk({nm, ".q"},    {28'd0, q},    {28'd0, eq});
        chk({nm, ".tc"},   {31'd0, tc},   {31'd0, etc});
        chk({nm, ".busy"}, {31'd0, busy}, {31'd0, ebusy});
        chk({nm, ".done"}, {31'd0, done}, {31'd0, edone});
    endtask

    // advance one clock; outputs are read 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic sp, input logic e, input logic w,
                          input logic [3:0] l, input logic ld, input logic [3:0] d);
        start = s; stop = sp; en = e; wrap = w; limit = l; we = ld; wq = d;
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // behavioural model state for the random phase (0=idle,1=count,2=done)
        int m_st, m_q, m_tc, n_st, n_q, n_tc;
        int c2, c4, c6;

        reset = 1'b0; s_start = 1'b0;
        set_in(0, 0, 0, 0, 4'd0, 0, 4'd0);

        // power-on asynchronous reset, checked before any clock edge
        #1 reset = 1'b1;
        #1 chk4("por", 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;

        // start,stop,en,wrap,limit,we,wq | q,tc,busy,done
        vecs = '{
            '{1,0,1,0,4'd5,0,4'd0, 4'd0,0,1,0},
            '{0,0,1,0,4'd5,0,4'd0, 4'd1,0,1,0},
            '{0,0,1,0,4'd5,0,4'd0, 4'd2,0,1,0},
            '{0,0,1,0,4'd5,0,4'd0, 4'd3,0,1,0},
            '{0,0,1,0,4'd5,0,4'd0, 4'd4,0,1,0},
            '{0,0,1,0,4'd5,0,4'd0, 4'd5,0,1,0},
            '{0,0,1,0,4'd5,0,4'd0, 4'd5,1,0,1},
            '{0,0,1,0,4'd5,0,4'd0, 4'd5,0,0,1},
            '{1,0,1,1,4'd3,0,4'd0, 4'd0,0,1,0},
            '{0,0,1,1,4'd3,0,4'd0, 4'd1,0,1,0},
            '{0,0,1,1,4'd3,0,4'd0, 4'd2,0,1,0},
            '{0,0,1,1,4'd3,0,4'd0, 4'd3,0,1,0},
            '{0,0,1,1,4'd3,0,4'd0, 4'd0,1,1,0},
            '{0,0,1,1,4'd3,0,4'd0, 4'd1,0,1,0},
            '{0,0,1,1,4'd3,0,4'd0, 4'd2,0,1,0},
            '{0,0,1,1,4'd3,0,4'd0, 4'd3,0,1,0},
            '{0,0,1,1,4'd3,0,4'd0, 4'd0,1,1,0},
            '{0,0,1,1,4'd3,0,4'd0, 4'd1,0,1,0},
            '{0,0,1,1,4'd3,0,4'd0, 4'd2,0,1,0},
            '{0,1,1,1,4'd3,0,4'd0, 4'd2,0,0,0},
            '{1,0,1,1,4'd0,0,4'd0, 4'd0,0,1,0},
            '{0,0,1,1,4'd0,0,4'd0, 4'd0,1,1,0},
            '{0,0,1,1,4'd0,0,4'd0, 4'd0,1,1,0},
            '{0,0,1,0,4'd0,0,4'd0, 4'd0,1,0,1},
            '{0,0,1,0,4'd0,1,4'd9, 4'd9,0,0,1}
        };

        for (int i = 0; i < 25; i++) begin
            set_in(vecs[i].start, vecs[i].stop, vecs[i].en, vecs[i].wrap,
                   vecs[i].limit, vecs[i].we, vecs[i].wq);
            step();
            chk4($sformatf("vec%0d", i), vecs[i].eq, vecs[i].etc, vecs[i].ebusy, vecs[i].edone);
        end

        // mid-count load above limit: rolls through 15 -> 0 before terminating
        set_in(1, 0, 1, 0, 4'd2, 0, 4'd0);  step(); chk4("ld_start", 4'd0, 0, 1, 0);
        start = 1'b0;                       step(); chk4("ld_q1", 4'd1, 0, 1, 0);
        we = 1'b1; wq = 4'b1110;            step(); chk4("ld_load", 4'd14, 0, 1, 0);
        we = 1'b0;
        step(); chk4("ld_15", 4'd15, 0, 1, 0);
        step(); chk4("ld_0",  4'd0,  0, 1, 0);
        step(); chk4("ld_1",  4'd1,  0, 1, 0);
        step(); chk4("ld_2",  4'd2,  0, 1, 0);
        step(); chk4("ld_tc", 4'd2,  1, 0, 1);

        // enable gating, then stop outranking a simultaneous start
        set_in(1, 0, 1, 0, 4'd10, 0, 4'd0); step(); chk4("en_start", 4'd0, 0, 1, 0);
        start = 1'b0;                       step(); chk4("en_q1", 4'd1, 0, 1, 0);
        en = 1'b0;                          step(); chk4("en_hold0", 4'd1, 0, 1, 0);
                                            step(); chk4("en_hold1", 4'd1, 0, 1, 0);
        en = 1'b1;                          step(); chk4("en_q2", 4'd2, 0, 1, 0);
        stop = 1'b1; start = 1'b1;          step(); chk4("stop_start", 4'd2, 0, 0, 0);
        stop = 1'b0; start = 1'b0;          step(); chk4("idle_hold", 4'd2, 0, 0, 0);

        // asynchronous reset mid-count, then idle until a start
        set_in(1, 0, 1, 0, 4'd10, 0, 4'd0); step();
        start = 1'b0; step(); step();
        #2 reset = 1'b1;
        #1 chk4("async_rst", 4'd0, 0, 0, 0);
        step();
        reset = 1'b0;
        step(); chk4("post_rst0", 4'd0, 0, 0, 0);
        step(); chk4("post_rst1", 4'd0, 0, 0, 0);

        // width sweep: limit = 2^N-1, one-shot, cycles from start to done
        set_in(1, 0, 1, 0, 4'd15, 0, 4'd0);
        s_start = 1'b1;
        step();
        start = 1'b0; s_start = 1'b0;
        c2 = 0; c4 = 0; c6 = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (done2 && c2 == 0) c2 = k;
            if (done  && c4 == 0) c4 = k;
            if (done6 && c6 == 0) c6 = k;
        end
        chk("sweep_n2_cycles", c2, 4);
        chk("sweep_n2_q", {30'd0, q2}, 3);
        chk("sweep_n4_cycles", c4, 16);
        chk("sweep_n4_q", {28'd0, q}, 15);
        chk("sweep_n6_cycles", c6, 64);
        chk("sweep_n6_q", {26'd0, q6}, 63);

        // randomized traffic against the behavioural model
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_st = 0; m_q = 0; m_tc = 0;
        limit = 4'($urandom_range(0, 15));
        wrap  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 19) == 0);
            we    = ($urandom_range(0, 15) == 0);
            en    = ($urandom_range(0, 3) != 0);
            wq    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) limit = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)  wrap  = ~wrap;

            n_st = m_st; n_q = m_q; n_tc = 0;
            if (stop) begin
                n_st = 0;
            end else if (start) begin
                n_st = 1; n_q = 0;
            end else if (m_st == 1 && en) begin
                if (m_q == int'(limit)) begin
                    n_tc = 1;
                    if (wrap) n_q = 0;
                    else      n_st = 2;
                end else begin
                    n_q = (m_q + 1) % 16;
                end
            end
            if (we) begin
                n_q = int'(wq); n_tc = 0;
            end
            m_st = n_st; m_q = n_q; m_tc = n_tc;

            step();
            chk4($sformatf("rnd%0d", i), 4'(m_q), 1'(m_tc), (m_st == 1), (m_st == 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
